// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin command arbiter in front of the SDRAM controller.
// Optional WAIT_ACK watchdog with sticky ERR is built when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
    parameter int ASIZE   = 23,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INIT_DONE,
    input  logic             P0_REQ,
    input  logic [1:0]       P0_CMD,
    input  logic [ASIZE-1:0] P0_ADDR,
    output logic             P0_ACK,
    input  logic             P1_REQ,
    input  logic [1:0]       P1_CMD,
    input  logic [ASIZE-1:0] P1_ADDR,
    output logic             P1_ACK,
    output logic [2:0]       CMD,
    output logic [ASIZE-1:0] ADDR,
    input  logic             CMD_ACK,
    output logic             BUSY,
    output logic             ERR
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    localparam logic [2:0] CMD_NOP = 3'b000;

    state_t           state, state_nxt;
    logic             sel, sel_nxt;
    logic             last, last_nxt;
    logic [1:0]       cmd_lat, cmd_lat_nxt;
    logic [ASIZE-1:0] addr_lat, addr_lat_nxt;
    logic [2:0]       cmd_nxt;
    logic [ASIZE-1:0] addr_nxt;
    logic             p0_ack_nxt, p1_ack_nxt;
    logic             grant_any, grant_p1;
    logic             timeout_hit;

    // Port 1 wins when alone, or when both request and port 0 won last time.
    assign grant_any = INIT_DONE && (P0_REQ || P1_REQ);
    assign grant_p1  = P1_REQ && (!P0_REQ || !last);

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;

    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_cnt <= '0;
            ERR    <= 1'b0;
        end else begin
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT_ACK)
                to_cnt <= to_cnt + 16'd1;
            // A CMD_ACK in the limit cycle is a normal completion, not an error.
            if (state == WAIT_ACK && !CMD_ACK && timeout_hit)
                ERR <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign ERR            = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_nxt    = state;
        sel_nxt      = sel;
        last_nxt     = last;
        cmd_lat_nxt  = cmd_lat;
        addr_lat_nxt = addr_lat;
        cmd_nxt      = CMD;
        addr_nxt     = ADDR;
        p0_ack_nxt   = 1'b0;
        p1_ack_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    sel_nxt      = grant_p1;
                    last_nxt     = grant_p1;
                    cmd_lat_nxt  = grant_p1 ? P1_CMD  : P0_CMD;
                    addr_lat_nxt = grant_p1 ? P1_ADDR : P0_ADDR;
                    // Null commands are acknowledged without touching the controller.
                    if (cmd_lat_nxt == 2'b00) begin
                        state_nxt  = GAP;
                        p0_ack_nxt = !grant_p1;
                        p1_ack_nxt = grant_p1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cmd_nxt   = {1'b0, cmd_lat};
                addr_nxt  = addr_lat;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (CMD_ACK || timeout_hit) begin
                    cmd_nxt    = CMD_NOP;
                    p0_ack_nxt = !sel;
                    p1_ack_nxt = sel;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (RESET) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            cmd_lat  <= 2'b00;
            addr_lat <= '0;
            CMD      <= CMD_NOP;
            ADDR     <= '0;
            P0_ACK   <= 1'b0;
            P1_ACK   <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            cmd_lat  <= cmd_lat_nxt;
            addr_lat <= addr_lat_nxt;
            CMD      <= cmd_nxt;
            ADDR     <= addr_nxt;
            P0_ACK   <= p0_ack_nxt;
            P1_ACK   <= p1_ack_nxt;
            BUSY     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table plus scoreboard queue.
// Timeout scenarios are compiled in only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_port_arbiter;

    localparam int ASIZE   = 23;
    localparam int TIMEOUT = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             INIT_DONE;
    logic             P0_REQ;
    logic [1:0]       P0_CMD;
    logic [ASIZE-1:0] P0_ADDR;
    logic             P0_ACK;
    logic             P1_REQ;
    logic [1:0]       P1_CMD;
    logic [ASIZE-1:0] P1_ADDR;
    logic             P1_ACK;
    logic [2:0]       CMD;
    logic [ASIZE-1:0] ADDR;
    logic             CMD_ACK;
    logic             BUSY;
    logic             ERR;

    always #5 CLK = ~CLK;

    sdram_port_arbiter #(.ASIZE(ASIZE), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .INIT_DONE(INIT_DONE),
        .P0_REQ(P0_REQ), .P0_CMD(P0_CMD), .P0_ADDR(P0_ADDR), .P0_ACK(P0_ACK),
        .P1_REQ(P1_REQ), .P1_CMD(P1_CMD), .P1_ADDR(P1_ADDR), .P1_ACK(P1_ACK),
        .CMD(CMD), .ADDR(ADDR), .CMD_ACK(CMD_ACK), .BUSY(BUSY), .ERR(ERR)
    );

    typedef struct {
        logic             p0_req;
        logic [1:0]       p0_cmd;
        logic [ASIZE-1:0] p0_addr;
        logic             p1_req;
        logic [1:0]       p1_cmd;
        logic [ASIZE-1:0] p1_addr;
        int               ack_dly;
        logic             stray;
        logic             exp_port;
        logic [2:0]       exp_cmd;
        logic [ASIZE-1:0] exp_addr;
    } vec_t;

    typedef struct {
        logic             port;
        logic [2:0]       cmd;
        logic [ASIZE-1:0] addr;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd"},  32'(CMD),    32'd0);
        check({tag, "_busy"}, 32'(BUSY),   32'd0);
        check({tag, "_ack0"}, 32'(P0_ACK), 32'd0);
        check({tag, "_ack1"}, 32'(P1_ACK), 32'd0);
        check({tag, "_err"},  32'(ERR),    32'(exp_err));
    endtask

    task automatic apply(input vec_t v);
        P0_REQ  = v.p0_req;
        P0_CMD  = v.p0_cmd;
        P0_ADDR = v.p0_addr;
        P1_REQ  = v.p1_req;
        P1_CMD  = v.p1_cmd;
        P1_ADDR = v.p1_addr;
    endtask

    // Entered at the negedge of the IDLE cycle that grants; leaves at the negedge of GAP.
    task automatic run_txn(input int ack_dly, input logic stray, input string tag);
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb: actual=empty required=entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_g_busy"}, 32'(BUSY),   32'd1);
        check({tag, "_g_cmd"},  32'(CMD),    32'd0);
        check({tag, "_g_ack0"}, 32'(P0_ACK), 32'(e.cmd == 3'b000 && e.port == 1'b0));
        check({tag, "_g_ack1"}, 32'(P1_ACK), 32'(e.cmd == 3'b000 && e.port == 1'b1));
        if (e.cmd == 3'b000)
            return;
        CMD_ACK = stray;
        tick();
        CMD_ACK = 1'b0;
        check({tag, "_cmd"},  32'(CMD),             32'(e.cmd));
        check({tag, "_addr"}, 32'(ADDR),            32'(e.addr));
        check({tag, "_wack"}, 32'(P0_ACK | P1_ACK), 32'd0);
        for (int k = 0; k < ack_dly; k++) begin
            tick();
            check({tag, "_hold"}, 32'(CMD), 32'(e.cmd));
        end
        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        check({tag, "_nop"},  32'(CMD),    32'd0);
        check({tag, "_ack0"}, 32'(P0_ACK), 32'(e.port == 1'b0));
        check({tag, "_ack1"}, 32'(P1_ACK), 32'(e.port == 1'b1));
        check({tag, "_gbsy"}, 32'(BUSY),   32'd1);
        check({tag, "_err"},  32'(ERR),    32'(exp_err));
    endtask

    initial begin
        int bad;
        vec_t quiet;

        // p0_req p0_cmd p0_addr | p1_req p1_cmd p1_addr | dly stray | port cmd addr
        vecs[0] = '{1'b0, 2'b00, 23'h000000, 1'b1, 2'b10, 23'h7FFFFF, 3, 1'b0, 1'b1, 3'b010, 23'h7FFFFF};
        vecs[1] = '{1'b1, 2'b01, 23'h000100, 1'b1, 2'b10, 23'h000200, 1, 1'b0, 1'b0, 3'b001, 23'h000100};
        vecs[2] = '{1'b1, 2'b11, 23'h000300, 1'b1, 2'b10, 23'h000200, 1, 1'b0, 1'b1, 3'b010, 23'h000200};
        vecs[3] = '{1'b1, 2'b11, 23'h000300, 1'b1, 2'b01, 23'h000400, 1, 1'b0, 1'b0, 3'b011, 23'h000300};
        vecs[4] = '{1'b1, 2'b00, 23'h000055, 1'b1, 2'b01, 23'h000400, 1, 1'b0, 1'b1, 3'b001, 23'h000400};
        vecs[5] = '{1'b1, 2'b00, 23'h000055, 1'b0, 2'b00, 23'h000000, 0, 1'b0, 1'b0, 3'b000, 23'h000055};
        vecs[6] = '{1'b1, 2'b10, 23'h0ABCDE, 1'b1, 2'b00, 23'h000066, 0, 1'b0, 1'b1, 3'b000, 23'h000066};
        vecs[7] = '{1'b1, 2'b10, 23'h0ABCDE, 1'b0, 2'b00, 23'h000000, 0, 1'b1, 1'b0, 3'b010, 23'h0ABCDE};
        quiet   = '{1'b0, 2'b00, 23'h000000, 1'b0, 2'b00, 23'h000000, 0, 1'b0, 1'b0, 3'b000, 23'h000000};

        RESET     = 1'b1;
        INIT_DONE = 1'b0;
        CMD_ACK   = 1'b0;
        apply(quiet);
        tick();
        tick();
        RESET = 1'b0;
        check_idle("reset");

        // Requests must be ignored until the controller finishes initialisation.
        P0_REQ  = 1'b1;
        P0_CMD  = 2'b01;
        P0_ADDR = 23'h000123;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (CMD != 3'b000 || BUSY || P0_ACK || P1_ACK)
                bad++;
        end
        check("init_gate_quiet_cycles", 32'(bad), 32'd0);
        INIT_DONE = 1'b1;
        sb.push_back('{1'b0, 3'b001, 23'h000123});
        run_txn(0, 1'b0, "init");

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            tick();
            check_idle($sformatf("v%0d_idle", i));
            sb.push_back('{vecs[i].exp_port, vecs[i].exp_cmd, vecs[i].exp_addr});
            run_txn(vecs[i].ack_dly, vecs[i].stray, $sformatf("v%0d", i));
        end
        apply(quiet);
        tick();
        check_idle("table_end");

        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        check_idle("stray_idle");
        tick();
        check_idle("stray_idle2");

        // Port 1 holds the grant when reset hits; port 0 must win afterwards.
        P0_REQ  = 1'b1;
        P0_CMD  = 2'b01;
        P0_ADDR = 23'h000111;
        P1_REQ  = 1'b1;
        P1_CMD  = 2'b10;
        P1_ADDR = 23'h000222;
        tick();
        tick();
        check("rst_pre_cmd",  32'(CMD),  32'd2);
        check("rst_pre_addr", 32'(ADDR), 32'h222);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_idle("rst_mid");
        sb.push_back('{1'b0, 3'b001, 23'h000111});
        run_txn(1, 1'b0, "post_rst");
        apply(quiet);
        tick();
        check_idle("post_rst_idle");

`ifdef SDRAM_ARB_TIMEOUT_EN
        P0_REQ  = 1'b1;
        P0_CMD  = 2'b01;
        P0_ADDR = 23'h000333;
        sb.push_back('{1'b0, 3'b001, 23'h000333});
        run_txn(7, 1'b0, "to_ack8");
        P0_REQ = 1'b0;
        tick();
        check_idle("to_ack8_idle");

        P0_REQ  = 1'b1;
        P0_CMD  = 2'b10;
        P0_ADDR = 23'h000444;
        tick();
        tick();
        check("to_cmd", 32'(CMD), 32'd2);
        bad = 0;
        while (bad < 20 && !P0_ACK) begin
            tick();
            bad++;
        end
        check("to_latency", 32'(bad), 32'd8);
        check("to_err",     32'(ERR), 32'd1);
        check("to_nop",     32'(CMD), 32'd0);
        exp_err = 1'b1;
        P0_REQ  = 1'b0;
        tick();
        check_idle("to_idle");
        repeat (5) tick();
        check("to_sticky", 32'(ERR), 32'd1);
        RESET = 1'b1;
        tick();
        RESET   = 1'b0;
        exp_err = 1'b0;
        check_idle("to_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
